// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, combinational imem port and a 2-entry
// {pc, inst} prefetch FIFO feeding decode over a valid/ready handshake.
//
// Decode handshake: if_valid is high whenever the FIFO holds an entry; the
// head entry (if_inst/if_pc/if_pc_plus4) is consumed on a cycle where
// if_valid & if_ready are both high, and it is held stable until then.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        fault,
    output logic [15:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  occ_q, occ_d;
    logic        fault_q, fault_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] buf_pc_q [2];
    logic [31:0] buf_pc_d [2];
    logic [31:0] buf_inst_q [2];
    logic [31:0] buf_inst_d [2];

    logic pop;
    logic fetch;
    logic redirect_misaligned;

    assign if_valid    = (occ_q != 2'd0);
    assign if_inst     = buf_inst_q[0];
    assign if_pc       = buf_pc_q[0];
    assign if_pc_plus4 = buf_pc_q[0] + 32'd4;
    assign imem_addr   = pc_q;
    assign fault       = fault_q;
    assign fetch_count = cnt_q;

    assign pop   = if_valid & if_ready;
    // A pop frees a slot in the same cycle, so a full buffer can still fetch.
    assign fetch = ~halt & ~fault_q & ~redirect_valid & ((occ_q < 2'd2) | pop);
    assign redirect_misaligned = (redirect_target[1:0] != 2'b00);

    always_comb begin
        pc_d       = pc_q;
        occ_d      = occ_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;

        if (redirect_valid) begin
            // Flush wins over any pop this cycle; the popped entry is simply dropped.
            occ_d = 2'd0;
            if (redirect_misaligned) begin
                fault_d = 1'b1;
            end else begin
                pc_d = redirect_target;
            end
        end else if (fetch) begin
            pc_d  = pc_q + 32'd4;
            cnt_d = cnt_q + 16'd1;
            if (pop) begin
                if (occ_q == 2'd2) begin
                    buf_pc_d[0]   = buf_pc_q[1];
                    buf_inst_d[0] = buf_inst_q[1];
                    buf_pc_d[1]   = pc_q;
                    buf_inst_d[1] = imem_inst;
                end else begin
                    buf_pc_d[0]   = pc_q;
                    buf_inst_d[0] = imem_inst;
                end
            end else begin
                buf_pc_d[occ_q[0]]   = pc_q;
                buf_inst_d[occ_q[0]] = imem_inst;
                occ_d                = occ_q + 2'd1;
            end
        end else if (pop) begin
            buf_pc_d[0]   = buf_pc_q[1];
            buf_inst_d[0] = buf_inst_q[1];
            occ_d         = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            occ_q         <= 2'd0;
            fault_q       <= 1'b0;
            cnt_q         <= 16'd0;
            buf_pc_q[0]   <= 32'd0;
            buf_pc_q[1]   <= 32'd0;
            buf_inst_q[0] <= 32'd0;
            buf_inst_q[1] <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            occ_q         <= occ_d;
            fault_q       <= fault_d;
            cnt_q         <= cnt_d;
            buf_pc_q[0]   <= buf_pc_d[0];
            buf_pc_q[1]   <= buf_pc_d[1];
            buf_inst_q[0] <= buf_inst_d[0];
            buf_inst_q[1] <= buf_inst_d[1];
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure, redirect,
// misaligned-redirect fault, halt drain, reset mid-operation and PC wrap.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_ready;

    logic [31:0] imem_addr, imem_inst;
    logic        if_valid;
    logic [31:0] if_inst, if_pc, if_pc_plus4;
    logic        fault;
    logic [15:0] fetch_count;

    logic [31:0] w_imem_addr, w_imem_inst;
    logic        w_if_valid;
    logic [31:0] w_if_inst, w_if_pc, w_if_pc_plus4;
    logic        w_fault;
    logic [15:0] w_fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory: LW-style words tagged with their address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[13:0], 18'h0} | 32'h0000_2003;
    endfunction

    assign imem_inst   = mem_word(imem_addr);
    assign w_imem_inst = mem_word(w_imem_addr);

    instruction_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .halt(halt), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4), .fault(fault), .fetch_count(fetch_count)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_inst(w_imem_inst),
        .halt(halt), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(w_if_valid), .if_ready(if_ready), .if_inst(w_if_inst), .if_pc(w_if_pc),
        .if_pc_plus4(w_if_pc_plus4), .fault(w_fault), .fetch_count(w_fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0; if_ready = 1'b1;

        // Streaming
        do_reset();
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_count", {16'd0, fetch_count}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stream_valid", {31'd0, if_valid}, 32'd1);
            check("stream_pc", if_pc, 32'(i * 4));
            check("stream_inst", if_inst, mem_word(32'(i * 4)));
            check("stream_pc4", if_pc_plus4, 32'(i * 4 + 4));
            if (i == 0) begin
                check("wrap_first_pc", w_if_pc, 32'hFFFF_FFFC);
                check("wrap_first_pc4", w_if_pc_plus4, 32'd0);
            end
            if (i == 1) check("wrap_second_pc", w_if_pc, 32'd0);
        end
        check("stream_count", {16'd0, fetch_count}, 32'd5);

        // Backpressure: five cycles of if_ready=0 from reset release
        if_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_pc", if_pc, 32'd0);
            check("bp_hold_inst", if_inst, mem_word(32'd0));
        end
        check("bp_addr", imem_addr, 32'd8);
        check("bp_count", {16'd0, fetch_count}, 32'd2);
        if_ready = 1'b1;
        step(); check("bp_pc_a", if_pc, 32'd4);
        step(); check("bp_pc_b", if_pc, 32'd8);
        step(); check("bp_pc_c", if_pc, 32'd12);
        check("bp_valid", {31'd0, if_valid}, 32'd1);

        // Redirect to 88 while if_pc = 80
        do_reset();
        for (int i = 0; i < 21; i++) step();
        check("rd_pre_pc", if_pc, 32'd80);
        redirect_valid = 1'b1; redirect_target = 32'd88;
        step();
        redirect_valid = 1'b0;
        check("rd_flush_valid", {31'd0, if_valid}, 32'd0);
        check("rd_addr", imem_addr, 32'd88);
        check("rd_count_hold", {16'd0, fetch_count}, 32'd21);
        step();
        check("rd_valid", {31'd0, if_valid}, 32'd1);
        check("rd_pc", if_pc, 32'd88);
        check("rd_inst", if_inst, mem_word(32'd88));
        check("rd_next_addr", imem_addr, 32'd92);
        check("rd_count", {16'd0, fetch_count}, 32'd22);

        // Misaligned redirect -> sticky fault
        redirect_valid = 1'b1; redirect_target = 32'h0000_005A;
        step();
        redirect_valid = 1'b0;
        check("flt_set", {31'd0, fault}, 32'd1);
        check("flt_valid", {31'd0, if_valid}, 32'd0);
        check("flt_addr", imem_addr, 32'd92);
        for (int i = 0; i < 3; i++) step();
        check("flt_sticky", {31'd0, fault}, 32'd1);
        check("flt_count", {16'd0, fetch_count}, 32'd22);
        check("flt_valid2", {31'd0, if_valid}, 32'd0);
        do_reset();
        check("flt_clear", {31'd0, fault}, 32'd0);
        check("flt_rst_addr", imem_addr, 32'd0);
        step();
        check("flt_restart_pc", if_pc, 32'd0);
        check("flt_restart_valid", {31'd0, if_valid}, 32'd1);

        // Halt with two buffered entries
        if_ready = 1'b0;
        do_reset();
        step(); step();
        halt = 1'b1; if_ready = 1'b1;
        step();
        check("halt_pc_a", if_pc, 32'd4);
        check("halt_addr_a", imem_addr, 32'd8);
        step();
        check("halt_empty", {31'd0, if_valid}, 32'd0);
        step();
        check("halt_still_empty", {31'd0, if_valid}, 32'd0);
        check("halt_addr_b", imem_addr, 32'd8);
        check("halt_count", {16'd0, fetch_count}, 32'd2);
        redirect_valid = 1'b1; redirect_target = 32'd40;
        step();
        redirect_valid = 1'b0;
        check("halt_rd_addr", imem_addr, 32'd40);
        step();
        check("halt_rd_valid", {31'd0, if_valid}, 32'd0);
        halt = 1'b0;
        step();
        check("unhalt_pc", if_pc, 32'd40);
        check("unhalt_valid", {31'd0, if_valid}, 32'd1);

        // Reset with the buffer full
        if_ready = 1'b0;
        step();
        check("mid_full_addr", imem_addr, 32'd48);
        do_reset();
        check("mid_valid", {31'd0, if_valid}, 32'd0);
        check("mid_count", {16'd0, fetch_count}, 32'd0);
        check("mid_addr", imem_addr, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
